// File: rtl/full_handshake_rx_pkg.sv
// Shared definitions for the four-phase CDC handshake (state encodings, default width).
package full_handshake_rx_pkg;

  localparam int unsigned DEFAULT_DW = 32;

  // The transmitter uses the same IDLE/ASSERT encodings.
  localparam logic [2:0] STATE_IDLE   = 3'b001;
  localparam logic [2:0] STATE_ASSERT = 3'b010;
  localparam logic [2:0] STATE_HOLD   = 3'b100;

  typedef enum logic [2:0] {
    StIdle   = STATE_IDLE,
    StAssert = STATE_ASSERT,
    StHold   = STATE_HOLD
  } rx_state_e;

endpackage

// File: rtl/full_handshake_rx_if.sv
// Handshake bus between the TX domain, the RX receiver and the local consumer.
interface full_handshake_rx_if
  import full_handshake_rx_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW
);
  logic          req_i;
  logic [DW-1:0] req_data_i;
  logic          ack_o;
  logic          recv_valid_o;
  logic [DW-1:0] recv_data_o;
  logic          recv_ready_i;
  logic          idle_o;

  modport master (
    output req_i, req_data_i, recv_ready_i,
    input  ack_o, recv_valid_o, recv_data_o, idle_o
  );

  modport slave (
    input  req_i, req_data_i, recv_ready_i,
    output ack_o, recv_valid_o, recv_data_o, idle_o
  );
endinterface

// File: rtl/full_handshake_rx_sync_2ff.sv
// Two-flop synchroniser with synchronous active-low reset to zero.
module sync_2ff #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DW-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/full_handshake_rx.sv
// Four-phase handshake receiver: synchronises req, captures data once, acks, delivers word.
// Define FULL_HANDSHAKE_RX_BP_EN to enable consumer backpressure (HOLD state).
module full_handshake_rx
  import full_handshake_rx_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW
) (
  input logic             clk,
  input logic             rst_n,
  full_handshake_rx_if.slave bus
);
  rx_state_e     state_q, state_d;
  logic          ack_q, ack_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          req_s;
  logic          buf_free;
  logic          consume;
  logic          capture;

  sync_2ff #(
    .DW (1)
  ) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.req_i),
    .q     (req_s)
  );

`ifdef FULL_HANDSHAKE_RX_BP_EN
  assign consume  = valid_q & bus.recv_ready_i;
  // Freeing in the consume cycle itself allows back-to-back delivery.
  assign buf_free = ~valid_q | consume;
`else
  assign consume  = valid_q;
  assign buf_free = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = consume ? 1'b0 : valid_q;
    data_d  = data_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_s) begin
          if (buf_free) begin
            capture = 1'b1;
            ack_d   = 1'b1;
            state_d = StAssert;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (buf_free) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = StAssert;
        end
      end
      StAssert: begin
        ack_d = 1'b1;
        // Only a low req_s re-arms IDLE, so a held request captures once.
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
    if (capture) begin
      valid_d = 1'b1;
      data_d  = bus.req_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.ack_o        = ack_q;
  assign bus.recv_valid_o = valid_q;
  assign bus.recv_data_o  = data_q;
  assign bus.idle_o       = (state_q == StIdle) & ~ack_q & ~valid_q;

endmodule

// File: tb/tb_full_handshake_rx.sv
// Self-checking bench for full_handshake_rx: vector table plus multi-cycle sequences.
module tb_full_handshake_rx;

  logic clk;
  logic rst_n;
  logic tx_clk;

  full_handshake_rx_if #(.DW(32)) bus ();

  full_handshake_rx #(
    .DW (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;
  initial tx_clk = 1'b0;
  always #7 tx_clk = ~tx_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural TX side: two-flop ack synchroniser on the TX clock
  logic tx_ack_m, tx_ack_s;
  always @(posedge tx_clk) begin
    tx_ack_m <= bus.ack_o;
    tx_ack_s <= tx_ack_m;
  end

  logic        mon_en = 1'b0;
  logic [31:0] got[$];
  always @(posedge clk) begin
    #1;
    if (mon_en && bus.recv_valid_o === 1'b1) got.push_back(bus.recv_data_o);
  end

  task automatic tx_send(input logic [31:0] v);
    int n;
    @(negedge tx_clk);
    bus.req_data_i = v;
    bus.req_i      = 1'b1;
    n = 0;
    while (tx_ack_s !== 1'b1 && n < 100) begin
      @(posedge tx_clk); #1;
      n++;
    end
    chk($sformatf("tx%0d_ack_rise", v), {31'b0, tx_ack_s}, 32'd1);
    @(negedge tx_clk);
    bus.req_i = 1'b0;
    n = 0;
    while (tx_ack_s !== 1'b0 && n < 100) begin
      @(posedge tx_clk); #1;
      n++;
    end
    chk($sformatf("tx%0d_ack_fall", v), {31'b0, tx_ack_s}, 32'd0);
  endtask

  task automatic rx_edges(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst_n;
    logic        req;
    logic [31:0] data;
    logic        ack;
    logic        valid;
    logic [31:0] rdata;
    logic        idle;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int pulses;
    int drops;

    // Inputs applied before an edge, outputs expected just after it.
    vecs[0]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'hA5A5_5A5A, 1'b1, 1'b1, 32'hA5A5_5A5A, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'hA5A5_5A5A, 1'b1, 1'b0, 32'hA5A5_5A5A, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'hA5A5_5A5A, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'hA5A5_5A5A, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA5A5_5A5A, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'hA5A5_5A5A, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'hA5A5_5A5A, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_1234, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[16] = '{1'b1, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[17] = '{1'b1, 1'b1, 32'h0000_0055, 1'b1, 1'b1, 32'h0000_0055, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0055, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0055, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0055, 1'b1};

    rst_n            = 1'b0;
    bus.req_i        = 1'b0;
    bus.req_data_i   = '0;
    bus.recv_ready_i = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rst_n          = vecs[i].rst_n;
      bus.req_i      = vecs[i].req;
      bus.req_data_i = vecs[i].data;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ack", i),   {31'b0, bus.ack_o},        {31'b0, vecs[i].ack});
      chk($sformatf("vec%0d_valid", i), {31'b0, bus.recv_valid_o}, {31'b0, vecs[i].valid});
      chk($sformatf("vec%0d_data", i),  bus.recv_data_o,           vecs[i].rdata);
      chk($sformatf("vec%0d_idle", i),  {31'b0, bus.idle_o},       {31'b0, vecs[i].idle});
    end

    // Held request: one capture, ack stays high once raised.
    @(negedge clk);
    bus.req_i      = 1'b1;
    bus.req_data_i = 32'h0000_0077;
    pulses = 0;
    drops  = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.recv_valid_o === 1'b1) pulses++;
      if (i >= 2 && bus.ack_o !== 1'b1) drops++;
    end
    chk("held_pulses", pulses, 1);
    chk("held_ack_drops", drops, 0);
    chk("held_data", bus.recv_data_o, 32'h0000_0077);
    @(negedge clk);
    bus.req_i = 1'b0;
    rx_edges(4);
    chk("held_release_idle", {31'b0, bus.idle_o}, 32'd1);

    // Back-to-back transfers from a TX model on a 7:3 clock ratio.
    mon_en = 1'b1;
    for (int v = 0; v < 8; v++) tx_send(v);
    rx_edges(4);
    mon_en = 1'b0;
    chk("b2b_count", got.size(), 8);
    for (int v = 0; v < 8; v++) begin
      if (v < got.size()) chk($sformatf("b2b_word%0d", v), got[v], v);
      else chk($sformatf("b2b_word%0d_missing", v), 32'hFFFF_FFFF, v);
    end

`ifdef FULL_HANDSHAKE_RX_BP_EN
    @(negedge clk);
    bus.recv_ready_i = 1'b0;
    bus.req_i        = 1'b1;
    bus.req_data_i   = 32'h1;
    rx_edges(3);
    chk("bp_first_ack", {31'b0, bus.ack_o}, 32'd1);
    chk("bp_first_data", bus.recv_data_o, 32'h1);
    @(negedge clk);
    bus.req_i = 1'b0;
    rx_edges(3);
    chk("bp_first_release", {31'b0, bus.ack_o}, 32'd0);
    chk("bp_valid_held", {31'b0, bus.recv_valid_o}, 32'd1);
    @(negedge clk);
    bus.req_i      = 1'b1;
    bus.req_data_i = 32'h2;
    rx_edges(5);
    chk("bp_hold_ack", {31'b0, bus.ack_o}, 32'd0);
    chk("bp_hold_data", bus.recv_data_o, 32'h1);
    chk("bp_hold_idle", {31'b0, bus.idle_o}, 32'd0);
    @(negedge clk);
    bus.recv_ready_i = 1'b1;
    rx_edges(1);
    chk("bp_second_ack", {31'b0, bus.ack_o}, 32'd1);
    chk("bp_second_data", bus.recv_data_o, 32'h2);
    chk("bp_second_valid", {31'b0, bus.recv_valid_o}, 32'd1);
    @(negedge clk);
    bus.req_i = 1'b0;
    rx_edges(4);
    chk("bp_final_idle", {31'b0, bus.idle_o}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
